// File: rtl/cycle_block_pkg.sv
// Shared definitions for the block-cycle pulse generator and its receive-side tracker.
// Holds the tracker state encoding and the phase-count width helper.
package cycle_block_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } track_state_e;

    localparam int         ERR_COUNT_W   = 8;
    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    // Width of a 0..cpc-1 phase count; never narrower than one bit.
    function automatic int count_width(input int cpc);
        return (cpc > 1) ? $clog2(cpc) : 1;
    endfunction

endpackage

// File: rtl/cycle_phase_counter.sv
// Mod-CPC phase counter: resets to CPC-1 so the first pulse lands on phase 0,
// and can be forced to 0 to realign onto a received pulse.
module cycle_phase_counter
    import cycle_block_pkg::*;
#(
    parameter  int CPC = 4,
    localparam int CW  = count_width(CPC)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] LAST = CW'(CPC - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // NOTE: next-state logic gets its value on every path, so no latch is inferred.
    always_comb begin
        count_d = count_q + 1'b1;
        if (load_i || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= LAST;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cycle_block_tracker.sv
// Receive-side tracker for the block-cycle pulse: acquires and verifies the remote
// pulse train, then flywheels a local phase and flags every spacing error.
module cycle_block_tracker
    import cycle_block_pkg::*;
#(
    parameter  int CPC      = 4,
    parameter  int LOCK_CNT = 2,
    parameter  int LOSS_CNT = 2,
    localparam int CW       = count_width(CPC)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cycle_clk_in,
    output logic [CW-1:0]          count_out,
    output logic                   cycle_clk_out,
    output logic                   locked,
    output logic                   err,
    output logic [ERR_COUNT_W-1:0] err_count
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    localparam logic [CW-1:0] LAST     = CW'(CPC - 1);
    localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_CNT);
    localparam logic [BW-1:0] BAD_TGT  = BW'(LOSS_CNT);

    track_state_e          state_q;
    logic [GW-1:0]         good_q;
    logic [BW-1:0]         bad_q;
    logic                  locked_q;
    logic                  err_q;
    logic [ERR_COUNT_W-1:0] err_count_q;

    logic [CW-1:0] ph;
    logic          at_end;
    logic          on_time;
    logic          extra;
    logic          missing;
    logic          realign;
    logic          err_event;

    assign at_end  = (ph == LAST);
    assign on_time = cycle_clk_in && at_end;
    assign extra   = cycle_clk_in && !at_end;
    assign missing = !cycle_clk_in && at_end;

    // The phase is only pulled onto the input before lock; once locked it flywheels.
    assign realign   = ((state_q == ST_SEARCH) && cycle_clk_in) ||
                       ((state_q == ST_VERIFY) && extra);
    assign err_event = (state_q != ST_SEARCH) && (extra || missing);

    cycle_phase_counter #(.CPC(CPC)) u_phase (
        .clk     (clk),
        .reset   (reset),
        .load_i  (realign),
        .count_o (ph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            good_q      <= '0;
            bad_q       <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_q <= err_event;
            if (err_event && (err_count_q != ERR_COUNT_MAX)) begin
                err_count_q <= err_count_q + 1'b1;
            end

            case (state_q)
                ST_SEARCH: begin
                    if (cycle_clk_in) begin
                        good_q <= GW'(1);
                        if (LOCK_CNT == 1) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                            bad_q    <= '0;
                        end else begin
                            state_q <= ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (on_time) begin
                        good_q <= good_q + 1'b1;
                        if ((good_q + 1'b1) == GOOD_TGT) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                            bad_q    <= '0;
                        end
                    end else if (extra) begin
                        good_q <= GW'(1);
                    end else if (missing) begin
                        state_q <= ST_SEARCH;
                        good_q  <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (on_time) begin
                        bad_q <= '0;
                    end else if (extra || missing) begin
                        if ((bad_q + 1'b1) == BAD_TGT) begin
                            state_q  <= ST_SEARCH;
                            locked_q <= 1'b0;
                            good_q   <= '0;
                            bad_q    <= '0;
                        end else begin
                            bad_q <= bad_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign count_out     = ph;
    assign cycle_clk_out = locked_q && at_end;
    assign locked        = locked_q;
    assign err           = err_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_cycle_block_tracker.sv
// Directed bench for cycle_block_tracker (CPC=6, LOCK_CNT=2, LOSS_CNT=2):
// a hand-computed vector table plus an error-count saturation run.
module tb_cycle_block_tracker;

    logic       clk;
    logic       reset;
    logic       cycle_clk_in;
    logic [2:0] count_out;
    logic       cycle_clk_out;
    logic       locked;
    logic       err;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       din;
        logic [2:0] cnt;
        logic       cco;
        logic       lk;
        logic       er;
        logic [7:0] ec;
    } vec_t;

    vec_t vecs[$];

    cycle_block_tracker #(.CPC(6), .LOCK_CNT(2), .LOSS_CNT(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .cycle_clk_in  (cycle_clk_in),
        .count_out     (count_out),
        .cycle_clk_out (cycle_clk_out),
        .locked        (locked),
        .err           (err),
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic v(input logic r, input logic d, input int c, input logic cc,
                     input logic l, input logic e, input int ec);
        vec_t x;
        x.rst = r; x.din = d; x.cnt = 3'(c); x.cco = cc; x.lk = l; x.er = e; x.ec = 8'(ec);
        vecs.push_back(x);
    endtask

    // n idle cycles with the phase stepping from c0; cycle_clk_out only at phase 5 while locked.
    task automatic z(input int n, input int c0, input logic l, input int ec);
        for (int k = 0; k < n; k++) begin
            v(1'b0, 1'b0, c0 + k, l && ((c0 + k) == 5), l, 1'b0, ec);
        end
    endtask

    task automatic apply(input logic r, input logic d);
        reset        = r;
        cycle_clk_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        cycle_clk_in = 1'b0;

        // Reset, acquire, lock.
        v(1, 0, 5, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0);
        z(5, 1, 0, 0);
        v(0, 1, 0, 0, 1, 0, 0);
        z(5, 1, 1, 0);
        v(0, 1, 0, 0, 1, 0, 0);
        z(5, 1, 1, 0);
        // One missed pulse: err, lock held, no slip.
        v(0, 0, 0, 0, 1, 1, 1);
        z(5, 1, 1, 1);
        v(0, 1, 0, 0, 1, 0, 1);
        z(5, 1, 1, 1);
        // Two consecutive misses: lock drops on the second.
        v(0, 0, 0, 0, 1, 1, 2);
        z(5, 1, 1, 2);
        v(0, 0, 0, 0, 0, 1, 3);
        z(2, 1, 0, 3);
        // Reacquire at phase 2, then an extra pulse in VERIFY.
        v(0, 1, 0, 0, 0, 0, 3);
        z(2, 1, 0, 3);
        v(0, 1, 0, 0, 0, 1, 4);
        z(5, 1, 0, 4);
        v(0, 1, 0, 0, 1, 0, 4);
        z(5, 1, 1, 4);
        // Input held high while locked.
        v(0, 1, 0, 0, 1, 0, 4);
        v(0, 1, 1, 0, 1, 1, 5);
        v(0, 1, 2, 0, 0, 1, 6);
        v(0, 1, 0, 0, 0, 0, 6);
        v(0, 1, 0, 0, 0, 1, 7);
        z(5, 1, 0, 7);
        v(0, 1, 0, 0, 1, 0, 7);
        z(1, 1, 1, 7);
        // Reset mid-LOCKED, reset dominating an input pulse.
        v(1, 0, 5, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0);
        v(1, 1, 5, 0, 0, 0, 0);
        // Missing pulse in VERIFY returns to SEARCH.
        v(0, 1, 0, 0, 0, 0, 0);
        z(5, 1, 0, 0);
        v(0, 0, 0, 0, 0, 1, 1);
        z(1, 1, 0, 1);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].din);
            check($sformatf("v%0d count_out", i),     32'(count_out),     32'(vecs[i].cnt));
            check($sformatf("v%0d cycle_clk_out", i), 32'(cycle_clk_out), 32'(vecs[i].cco));
            check($sformatf("v%0d locked", i),        32'(locked),        32'(vecs[i].lk));
            check($sformatf("v%0d err", i),           32'(err),           32'(vecs[i].er));
            check($sformatf("v%0d err_count", i),     32'(err_count),     32'(vecs[i].ec));
        end

        // Continuous input from reset: first cycle acquires, every later cycle is an
        // extra pulse in VERIFY, so err_count after cycle k is k-1 until it pins at 255.
        apply(1'b1, 1'b0);
        check("sat reset err_count", 32'(err_count), 32'd0);
        for (int k = 1; k <= 300; k++) begin
            apply(1'b0, 1'b1);
            if (k == 1 || k == 100 || k == 255 || k == 256 || k == 257 || k == 300) begin
                check($sformatf("sat k=%0d err_count", k), 32'(err_count),
                      32'((k - 1) > 255 ? 255 : (k - 1)));
                check($sformatf("sat k=%0d err", k), 32'(err), 32'(k > 1));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
